fb_cell_writer: RTL

- Write-side controller for the VGA frame buffer.
- Accepts playfield cell-paint and grid-clear commands from game logic over a valid/ready handshake.
- Expands each command into a raster sequence of single-pixel frame-buffer writes.
- Issues writes only during blanking (in_display low), so the scan-out read path never sees a torn pixel.

---
 rtl/fb_pkg.sv | 37 +++
 rtl/fb_raster_counter.sv | 56 +++++
 rtl/fb_cell_writer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared frame-buffer constants: colour bit order, FSM encoding and default playfield geometry.
package fb_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned COL_W   = 4;
  localparam int unsigned ROW_W   = 5;
  localparam int unsigned COLOR_W = 3;

  localparam int unsigned COLOR_R = 0;
  localparam int unsigned COLOR_G = 1;
  localparam int unsigned COLOR_B = 2;

  localparam int unsigned DEF_CELL_SIZE = 16;
  localparam int unsigned DEF_GRID_X0   = 240;
  localparam int unsigned DEF_GRID_Y0   = 40;
  localparam int unsigned DEF_GRID_COLS = 10;
  localparam int unsigned DEF_GRID_ROWS = 20;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_PAINT_ENC = 2'd1;
  localparam logic [1:0] ST_CLEAR_ENC = 2'd2;
  localparam logic [1:0] ST_DONE_ENC  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_PAINT = ST_PAINT_ENC,
    ST_CLEAR = ST_CLEAR_ENC,
    ST_DONE  = ST_DONE_ENC
  } fb_state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COLOR_W-1:0] color;
  } fb_pix_t;

endpackage

// File: rtl/fb_raster_counter.sv
// 2-D px/py raster counter: px runs fastest, wraps at width and bumps py; last marks the final pixel.
module fb_raster_counter
  import fb_pkg::*;
#(
  parameter int unsigned CNT_W = COORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] height,
  output logic [CNT_W-1:0] px_nxt_c,
  output logic [CNT_W-1:0] py_nxt_c,
  output logic             last_c
);

  logic [CNT_W-1:0] px_q;
  logic [CNT_W-1:0] py_q;
  logic             px_wrap_c;
  logic             py_wrap_c;

  always_comb begin
    px_wrap_c = (px_q == width - CNT_W'(1));
    py_wrap_c = (py_q == height - CNT_W'(1));
    last_c    = px_wrap_c && py_wrap_c;
  end

  // clr has priority so a new command always starts from the origin
  always_comb begin
    px_nxt_c = px_q;
    py_nxt_c = py_q;
    if (clr) begin
      px_nxt_c = '0;
      py_nxt_c = '0;
    end else if (en) begin
      if (px_wrap_c) begin
        px_nxt_c = '0;
        py_nxt_c = py_wrap_c ? '0 : py_q + CNT_W'(1);
      end else begin
        px_nxt_c = px_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_q <= '0;
      py_q <= '0;
    end else begin
      px_q <= px_nxt_c;
      py_q <= py_nxt_c;
    end
  end

endmodule

// File: rtl/fb_cell_writer.sv
// Frame-buffer write controller: expands cell-paint / grid-clear commands into
// single-pixel writes that are only issued while the scan-out is in blanking.
module fb_cell_writer
  import fb_pkg::*;
#(
  parameter int unsigned CELL_SIZE = DEF_CELL_SIZE,
  parameter int unsigned GRID_X0   = DEF_GRID_X0,
  parameter int unsigned GRID_Y0   = DEF_GRID_Y0,
  parameter int unsigned GRID_COLS = DEF_GRID_COLS,
  parameter int unsigned GRID_ROWS = DEF_GRID_ROWS
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_clear,
  input  logic [COL_W-1:0]   cmd_col,
  input  logic [ROW_W-1:0]   cmd_row,
  input  logic [COLOR_W-1:0] cmd_color,
  input  logic               in_display,
  output logic               fb_we,
  output logic [COORD_W-1:0] fb_x,
  output logic [COORD_W-1:0] fb_y,
  output logic [COLOR_W-1:0] fb_data,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int unsigned GRID_W = GRID_COLS * CELL_SIZE;
  localparam int unsigned GRID_H = GRID_ROWS * CELL_SIZE;

  fb_state_e          state_q, state_d;
  logic [COORD_W-1:0] x0_q, x0_d;
  logic [COORD_W-1:0] y0_q, y0_d;
  fb_pix_t            pix_q, pix_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               ready_q, ready_d;

  logic               we_c;
  logic               in_range_c;
  logic               cnt_clr_c;
  logic               cnt_en_c;
  logic               last_c;
  logic [COORD_W-1:0] px_nxt_c;
  logic [COORD_W-1:0] py_nxt_c;
  logic [COORD_W-1:0] ext_w_c;
  logic [COORD_W-1:0] ext_h_c;
  logic [COORD_W-1:0] cell_x0_c;
  logic [COORD_W-1:0] cell_y0_c;
  logic [COLOR_W-1:0] color_c;

  // Write strobe and command decode
  always_comb begin
    we_c       = ((state_q == ST_PAINT) || (state_q == ST_CLEAR)) && !in_display;
    in_range_c = (COORD_W'(cmd_col) < COORD_W'(GRID_COLS)) &&
                 (COORD_W'(cmd_row) < COORD_W'(GRID_ROWS));
    cell_x0_c  = COORD_W'(GRID_X0) + COORD_W'(cmd_col) * COORD_W'(CELL_SIZE);
    cell_y0_c  = COORD_W'(GRID_Y0) + COORD_W'(cmd_row) * COORD_W'(CELL_SIZE);
    ext_w_c    = (state_q == ST_CLEAR) ? COORD_W'(GRID_W) : COORD_W'(CELL_SIZE);
    ext_h_c    = (state_q == ST_CLEAR) ? COORD_W'(GRID_H) : COORD_W'(CELL_SIZE);
    // frame-buffer colour word is {B,G,R}
    color_c    = {cmd_color[COLOR_B], cmd_color[COLOR_G], cmd_color[COLOR_R]};
  end

  fb_raster_counter #(
    .CNT_W (COORD_W)
  ) u_raster (
    .clk      (clock),
    .rst_n    (reset_n),
    .clr      (cnt_clr_c),
    .en       (cnt_en_c),
    .width    (ext_w_c),
    .height   (ext_h_c),
    .px_nxt_c (px_nxt_c),
    .py_nxt_c (py_nxt_c),
    .last_c   (last_c)
  );

  always_comb begin
    state_d   = state_q;
    x0_d      = x0_q;
    y0_d      = y0_q;
    pix_d     = pix_q;
    err_d     = 1'b0;
    cnt_clr_c = 1'b0;
    cnt_en_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_clear) begin
            state_d = ST_CLEAR;
            x0_d    = COORD_W'(GRID_X0);
            y0_d    = COORD_W'(GRID_Y0);
          end else if (in_range_c) begin
            state_d = ST_PAINT;
            x0_d    = cell_x0_c;
            y0_d    = cell_y0_c;
          end else begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end
          if (cmd_clear || in_range_c) begin
            cnt_clr_c   = 1'b1;
            pix_d.x     = x0_d;
            pix_d.y     = y0_d;
            pix_d.color = color_c;
          end
        end
      end
      ST_PAINT, ST_CLEAR: begin
        // the address register tracks the pixel to write next; held through display stalls
        if (we_c) begin
          cnt_en_c = 1'b1;
          if (last_c) begin
            state_d = ST_DONE;
          end else begin
            pix_d.x = x0_q + px_nxt_c;
            pix_d.y = y0_q + py_nxt_c;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      pix_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      pix_q   <= pix_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  assign cmd_ready = ready_q;
  assign fb_we     = we_c;
  assign fb_x      = pix_q.x;
  assign fb_y      = pix_q.y;
  assign fb_data   = pix_q.color;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
